// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator-CPU sequencer: opcodes, FSM states,
// opcode classes and the opcode -> ALU control word table.
package cpu_pkg;

    localparam int OPW = 5;

    // Opcode map (5-bit opcode field at the top of the instruction word)
    localparam logic [4:0] OP_ALU_LAST = 5'h12;
    localparam logic [4:0] OP_STORE    = 5'h13;
    localparam logic [4:0] OP_JMP      = 5'h14;
    localparam logic [4:0] OP_JZ       = 5'h15;
    localparam logic [4:0] OP_JN       = 5'h16;
    localparam logic [4:0] OP_HALT     = 5'h17;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_JUMP    = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_e;

    // ALU control words {zx,nx,zy,ny,f,no}
    localparam logic [5:0] ALU_ZERO   = 6'b101010;
    localparam logic [5:0] ALU_ONE    = 6'b111111;
    localparam logic [5:0] ALU_MONE   = 6'b111010;
    localparam logic [5:0] ALU_X      = 6'b001100;
    localparam logic [5:0] ALU_Y      = 6'b110000;
    localparam logic [5:0] ALU_NOTX   = 6'b001101;
    localparam logic [5:0] ALU_NOTY   = 6'b110001;
    localparam logic [5:0] ALU_NEGX   = 6'b001111;
    localparam logic [5:0] ALU_NEGY   = 6'b110011;
    localparam logic [5:0] ALU_XINC   = 6'b011111;
    localparam logic [5:0] ALU_YINC   = 6'b110111;
    localparam logic [5:0] ALU_XDEC   = 6'b001110;
    localparam logic [5:0] ALU_YDEC   = 6'b110010;
    localparam logic [5:0] ALU_ADD    = 6'b000010;
    localparam logic [5:0] ALU_XSUBY  = 6'b010011;
    localparam logic [5:0] ALU_YSUBX  = 6'b000111;
    localparam logic [5:0] ALU_AND    = 6'b000000;
    localparam logic [5:0] ALU_OR     = 6'b010101;

    // Opcode -> ALU control word; anything outside the ALU range yields the
    // harmless "constant zero" word so the datapath never sees an undefined code.
    function automatic logic [5:0] alu_ctrl_of(input logic [4:0] op);
        logic [5:0] ctrl;
        case (op)
            5'h00:   ctrl = ALU_ZERO;
            5'h01:   ctrl = ALU_ONE;
            5'h02:   ctrl = ALU_MONE;
            5'h03:   ctrl = ALU_X;
            5'h04:   ctrl = ALU_Y;
            5'h05:   ctrl = ALU_NOTX;
            5'h06:   ctrl = ALU_NOTY;
            5'h07:   ctrl = ALU_NEGX;
            5'h08:   ctrl = ALU_NEGY;
            5'h09:   ctrl = ALU_XINC;
            5'h0A:   ctrl = ALU_YINC;
            5'h0B:   ctrl = ALU_XDEC;
            5'h0C:   ctrl = ALU_YDEC;
            5'h0D:   ctrl = ALU_ADD;
            5'h0E:   ctrl = ALU_XSUBY;
            5'h0F:   ctrl = ALU_YSUBX;
            5'h10:   ctrl = ALU_AND;
            5'h11:   ctrl = ALU_OR;
            5'h12:   ctrl = ALU_Y;   // plain load of the memory operand
            default: ctrl = ALU_ZERO;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the two memories (slave).
interface cpu_sequencer_if #(
    parameter int IW = 16,
    parameter int AW = 11
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic          dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        input  imem_ack, imem_data, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        output imem_ack, imem_data, dmem_ack
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational opcode decoder: ALU control word plus the opcode class the
// sequencer branches on.
module alu_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic [5:0] alu_ctrl_o,
    output op_class_e  class_o
);

    // Table lookup for the ALU word and range/equality decode for the class
    always_comb begin
        alu_ctrl_o = alu_ctrl_of(opcode_i);
        class_o    = CLS_ILLEGAL;
        if (opcode_i <= OP_ALU_LAST) begin
            class_o = CLS_ALU;
        end else begin
            case (opcode_i)
                OP_STORE:            class_o = CLS_STORE;
                OP_JMP, OP_JZ, OP_JN: class_o = CLS_JUMP;
                OP_HALT:             class_o = CLS_HALT;
                default:             class_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 5-bit-opcode accumulator CPU.
// Owns pc and ir, fetches over the imem handshake, performs operand reads and
// accumulator stores over the dmem handshake, and strobes the accumulator.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_i,
    cpu_sequencer_if.master       mem_bus,
    input  logic                  zr_i,
    input  logic                  ng_i,
    output logic [5:0]            alu_ctrl_o,
    output logic                  load_acc_o,
    output logic [AW-1:0]         pc_o,
    output logic                  halted_o,
    output logic                  illegal_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;

    logic [4:0]    opcode_s;
    op_class_e     op_class_s;
    logic [5:0]    alu_ctrl_s;
    logic [AW-1:0] target_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] jump_pc_s;
    state_e        next_after_s;

    logic          imem_req_s;
    logic          dmem_req_s;
    logic          dmem_we_s;
    logic          load_acc_s;
    logic          illegal_s;
    logic          halted_s;

    assign opcode_s     = ir_q[IW-1:IW-OPW];
    assign target_s     = ir_q[AW-1:0];
    assign pc_inc_s     = pc_q + AW'(1);      // wraps modulo 2^AW
    assign next_after_s = run_i ? ST_FETCH : ST_IDLE;

    alu_decode u_alu_decode (
        .opcode_i   (opcode_s),
        .alu_ctrl_o (alu_ctrl_s),
        .class_o    (op_class_s)
    );

    // Branch resolution; zr/ng are looked at only while DECODE consumes this
    always_comb begin
        jump_pc_s = pc_inc_s;
        case (opcode_s)
            OP_JMP: jump_pc_s = target_s;
            OP_JZ: begin
                if (zr_i) begin
                    jump_pc_s = target_s;
                end else begin
                    jump_pc_s = pc_inc_s;
                end
            end
            OP_JN: begin
                if (ng_i) begin
                    jump_pc_s = target_s;
                end else begin
                    jump_pc_s = pc_inc_s;
                end
            end
            default: jump_pc_s = pc_inc_s;
        endcase
    end

    // Next-state logic and handshake/strobe outputs of the sequencer
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        load_acc_s = 1'b0;
        illegal_s  = 1'b0;
        halted_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (mem_bus.imem_ack) begin
                    ir_d    = mem_bus.imem_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (op_class_s)
                    CLS_ALU, CLS_STORE: state_d = ST_MEM;
                    CLS_JUMP: begin
                        pc_d    = jump_pc_s;
                        state_d = next_after_s;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    CLS_ILLEGAL: begin
                        illegal_s = 1'b1;
                        pc_d      = pc_inc_s;
                        state_d   = next_after_s;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (op_class_s == CLS_STORE);
                if (mem_bus.dmem_ack) begin
                    // accumulator captures the ALU result on this same edge
                    load_acc_s = (op_class_s == CLS_ALU);
                    pc_d       = pc_inc_s;
                    state_d    = next_after_s;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                state_d  = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, program counter and instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign mem_bus.imem_req  = imem_req_s;
    assign mem_bus.imem_addr = pc_q;
    assign mem_bus.dmem_req  = dmem_req_s;
    assign mem_bus.dmem_we   = dmem_we_s;
    assign mem_bus.dmem_addr = target_s;

    assign alu_ctrl_o = alu_ctrl_s;
    assign load_acc_o = load_acc_s;
    assign pc_o       = pc_q;
    assign halted_o   = halted_s;
    assign illegal_o  = illegal_s;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs, memory responders
// with programmable wait states, and a monitor that checks every handshake.
module tb_cpu_sequencer;

    localparam int IW = 16;
    localparam int AW = 11;

    localparam logic [1:0] K_FETCH = 2'd1;
    localparam logic [1:0] K_DMEM  = 2'd2;
    localparam logic [1:0] K_ILL   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [10:0] addr;
        logic        we;
        logic        load;
        logic [5:0]  alu;
        logic [7:0]  reqcyc;
        logic        stable;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          zr;
    logic          ng;
    logic [5:0]    alu_ctrl;
    logic          load_acc;
    logic [AW-1:0] pc;
    logic          halted;
    logic          illegal;

    int vectors     = 0;
    int miscompares = 0;

    int imem_wait = 0;
    int dmem_wait = 0;
    logic [IW-1:0] imem [0:2047];

    ev_t exp_q[$];
    int  fetch_cyc_q[$];
    int  load_cnt = 0;
    int  cycle    = 0;

    cpu_sequencer_if #(.IW(IW), .AW(AW)) mem_bus ();

    cpu_sequencer #(.IW(IW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .mem_bus    (mem_bus.master),
        .zr_i       (zr),
        .ng_i       (ng),
        .alu_ctrl_o (alu_ctrl),
        .load_acc_o (load_acc),
        .pc_o       (pc),
        .halted_o   (halted),
        .illegal_o  (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic ev_t mk_fetch(input logic [10:0] a, input int rc);
        ev_t e;
        e = '0;
        e.kind = K_FETCH; e.addr = a; e.reqcyc = 8'(rc); e.stable = 1'b1;
        return e;
    endfunction

    function automatic ev_t mk_dmem(input logic [10:0] a, input logic we, input logic ld,
                                    input logic [5:0] alu, input int rc, input logic st);
        ev_t e;
        e = '0;
        e.kind = K_DMEM; e.addr = a; e.we = we; e.load = ld; e.alu = alu;
        e.reqcyc = 8'(rc); e.stable = st;
        return e;
    endfunction

    function automatic ev_t mk_ill(input logic [10:0] a);
        ev_t e;
        e = '0;
        e.kind = K_ILL; e.addr = a; e.stable = 1'b1;
        return e;
    endfunction

    task automatic sb_compare(input ev_t obs);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got 0x%08h required none", obs);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard_event", {2'b00, obs}, {2'b00, e});
        end
    endtask

    // Instruction memory responder
    initial begin
        int icnt;
        icnt = 0;
        mem_bus.imem_ack  = 1'b0;
        mem_bus.imem_data = '0;
        forever begin
            @(negedge clk);
            if (rst || !mem_bus.imem_req) begin
                mem_bus.imem_ack = 1'b0;
                icnt = 0;
            end else if (icnt >= imem_wait) begin
                mem_bus.imem_ack  = 1'b1;
                mem_bus.imem_data = imem[mem_bus.imem_addr];
                icnt++;
            end else begin
                mem_bus.imem_ack = 1'b0;
                icnt++;
            end
        end
    end

    // Data memory responder
    initial begin
        int dcnt;
        dcnt = 0;
        mem_bus.dmem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mem_bus.dmem_req) begin
                mem_bus.dmem_ack = 1'b0;
                dcnt = 0;
            end else if (dcnt >= dmem_wait) begin
                mem_bus.dmem_ack = 1'b1;
                dcnt++;
            end else begin
                mem_bus.dmem_ack = 1'b0;
                dcnt++;
            end
        end
    end

    // Monitor: turns completed handshakes and illegal pulses into events
    initial begin
        int fcnt, dcnt;
        logic [10:0] faddr, daddr;
        logic fstab, dstab, dwe0;
        fcnt = 0; dcnt = 0; faddr = '0; daddr = '0; fstab = 1'b1; dstab = 1'b1; dwe0 = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cycle++;
            if (rst) begin
                fcnt = 0;
                dcnt = 0;
            end else begin
                if (mem_bus.imem_req) begin
                    if (fcnt == 0) begin
                        faddr = mem_bus.imem_addr; fstab = 1'b1;
                    end else if (mem_bus.imem_addr !== faddr) begin
                        fstab = 1'b0;
                    end
                    fcnt++;
                    if (mem_bus.imem_ack) begin
                        ev_t o;
                        o = mk_fetch(mem_bus.imem_addr, fcnt);
                        o.stable = fstab;
                        fetch_cyc_q.push_back(cycle);
                        sb_compare(o);
                        fcnt = 0;
                    end
                end else begin
                    fcnt = 0;
                end
                if (mem_bus.dmem_req) begin
                    if (dcnt == 0) begin
                        daddr = mem_bus.dmem_addr; dwe0 = mem_bus.dmem_we; dstab = 1'b1;
                    end else if (mem_bus.dmem_addr !== daddr || mem_bus.dmem_we !== dwe0) begin
                        dstab = 1'b0;
                    end
                    dcnt++;
                    if (mem_bus.dmem_ack) begin
                        sb_compare(mk_dmem(mem_bus.dmem_addr, mem_bus.dmem_we, load_acc,
                                           alu_ctrl, dcnt, dstab));
                        dcnt = 0;
                    end
                end else begin
                    dcnt = 0;
                end
                if (illegal) sb_compare(mk_ill(pc));
                if (load_acc) load_cnt++;
            end
        end
    end

    // Raise run until one fetch completes, then drop it so the instruction parks
    task automatic wait_fetch();
        int found;
        found = 0;
        run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (mem_bus.imem_req && mem_bus.imem_ack) begin
                found = 1;
                break;
            end
        end
        run = 1'b0;
        check("fetch_within_budget", found, 1);
    endtask

    task automatic exec_one();
        wait_fetch();
        repeat (8) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c, found, seen;
        for (int i = 0; i < 2048; i++) imem[i] = '0;
        rst = 1'b1; run = 1'b0; zr = 1'b0; ng = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        check("rst_pc",       pc, 0);
        check("rst_halted",   halted, 0);
        check("rst_illegal",  illegal, 0);
        check("rst_load_acc", load_acc, 0);
        check("rst_alu_ctrl", alu_ctrl, 6'b101010);
        check("rst_imem_req", mem_bus.imem_req, 0);
        check("rst_dmem_req", mem_bus.dmem_req, 0);
        check("rst_dmem_we",  mem_bus.dmem_we, 0);

        // ALU op 0x01 on addr 5, zero-wait memories
        imem[0] = 16'h0805;
        exp_q.push_back(mk_fetch(11'h000, 1));
        exp_q.push_back(mk_dmem(11'h005, 1'b0, 1'b1, 6'b111111, 1, 1'b1));
        rst = 1'b0; run = 1'b1;
        found = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (mem_bus.dmem_req) begin
                found = i;
                break;
            end
        end
        run = 1'b0;
        check("first_dmem_req_cycle", found, 3);
        repeat (4) @(negedge clk);
        #1;
        check("alu_pc_after", pc, 11'h001);
        check("idle_no_imem_req", mem_bus.imem_req, 0);

        // STORE to 0x7FF, data memory holds req for 3 cycles
        dmem_wait = 2;
        imem[1] = 16'h9FFF;
        exp_q.push_back(mk_fetch(11'h001, 1));
        exp_q.push_back(mk_dmem(11'h7FF, 1'b1, 1'b0, 6'b101010, 3, 1'b1));
        exec_one();
        check("store_pc_after", pc, 11'h002);
        dmem_wait = 0;

        // JZ 0x040 taken then not taken, with one imem wait state
        imem_wait = 1;
        zr = 1'b1;
        imem[2] = 16'hA840;
        exp_q.push_back(mk_fetch(11'h002, 2));
        exec_one();
        check("jz_taken_pc", pc, 11'h040);
        zr = 1'b0;
        imem[11'h040] = 16'hA840;
        exp_q.push_back(mk_fetch(11'h040, 2));
        exec_one();
        check("jz_not_taken_pc", pc, 11'h041);
        imem_wait = 0;

        // JN taken
        ng = 1'b1;
        imem[11'h041] = 16'hB123;
        exp_q.push_back(mk_fetch(11'h041, 1));
        exec_one();
        check("jn_taken_pc", pc, 11'h123);
        ng = 1'b0;

        // Undefined opcode 0x1A behaves as NOP with a single illegal pulse
        imem[11'h123] = 16'hD000;
        exp_q.push_back(mk_fetch(11'h123, 1));
        exp_q.push_back(mk_ill(11'h123));
        exec_one();
        check("illegal_pc", pc, 11'h124);

        // Run held: JMP 0x7FF, ALU 0x0D at 0x7FF (pc wraps), JMP 0x300, HALT
        imem[11'h124] = 16'hA7FF;
        imem[11'h7FF] = 16'h680A;
        imem[11'h000] = 16'hA300;
        imem[11'h300] = 16'hB800;
        exp_q.push_back(mk_fetch(11'h124, 1));
        exp_q.push_back(mk_fetch(11'h7FF, 1));
        exp_q.push_back(mk_dmem(11'h00A, 1'b0, 1'b1, 6'b000010, 1, 1'b1));
        exp_q.push_back(mk_fetch(11'h000, 1));
        exp_q.push_back(mk_fetch(11'h300, 1));
        fetch_cyc_q.delete();
        run = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("chain_fetch_count", fetch_cyc_q.size(), 4);
        if (fetch_cyc_q.size() == 4) begin
            check("gap_jump",    fetch_cyc_q[1] - fetch_cyc_q[0], 2);
            check("gap_alu",     fetch_cyc_q[2] - fetch_cyc_q[1], 3);
            check("gap_jump2",   fetch_cyc_q[3] - fetch_cyc_q[2], 2);
        end
        check("halted_set", halted, 1);
        check("halt_pc_held", pc, 11'h300);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mem_bus.imem_req || mem_bus.dmem_req) seen++;
        end
        check("halt_no_requests", seen, 0);
        check("halted_sticky", halted, 1);
        rst = 1'b1;
        #1;
        check("rst_clears_halted", halted, 0);
        check("rst_clears_pc", pc, 0);
        run = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Reset in the middle of a long data-memory wait
        imem[0] = 16'h0805;
        dmem_wait = 1000;
        exp_q.push_back(mk_fetch(11'h000, 1));
        wait_fetch();
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (mem_bus.dmem_req) begin
                found = 1;
                break;
            end
        end
        check("mem_wait_reached", found, 1);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_dmem_req", mem_bus.dmem_req, 0);
        check("abort_load_acc", load_acc, 0);
        check("abort_pc", pc, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        dmem_wait = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (mem_bus.imem_req || mem_bus.dmem_req) seen++;
        end
        check("abort_parks_idle", seen, 0);

        check("leftover_events", exp_q.size(), 0);
        check("load_acc_pulses", load_cnt, 2);
        c = vectors;
        $display("== %0d vectors applied, %0d miscompares ==", c, miscompares);
        $finish;
    end

endmodule
